alu_ex_reg: RTL and testbench

- Execute-to-memory pipeline register that directly consumes the 24-bit adder result and overflow flag.
- Captures the result, destination and write-enable each cycle, and converts a signed overflow into an overflow exception that suppresses writeback.
- Maintains a sticky overflow status flag and a saturating overflow counter for the control unit.
- Sits between the ALU and the memory/writeback stage; honours pipeline stall and flush.

---
 rtl/alu_ex_reg_pkg.sv | 24 ++
 rtl/ex_ov_stat.sv | 47 ++++
 rtl/alu_ex_reg.sv | 105 ++++++++++
 tb/tb_alu_ex_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_ex_reg_pkg.sv
// Shared widths, exception codes and the exception-selection helper for the EX/MEM stage.
package alu_ex_reg_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 5;
    localparam int EXP_W  = 3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [EXP_W-1:0] {
        EXP_NO  = 3'd0,
        EXP_OVF = 3'd4
    } exp_code_e;

    // Upstream exceptions outrank an ALU overflow.
    function automatic logic [EXP_W-1:0] sel_exp(input logic [EXP_W-1:0] id_exp,
                                                 input logic              of);
        if (id_exp != EXP_NO) return id_exp;
        else if (of)          return EXP_OVF;
        else                  return EXP_NO;
    endfunction

endpackage

// File: rtl/ex_ov_stat.sv
// Sticky overflow flag and saturating overflow counter; a same-edge event beats a clear.
module ex_ov_stat
    import alu_ex_reg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ov_evt,
    input  logic             ov_clr,
    output logic             ov_flag,
    output logic [CNT_W-1:0] ov_count
);

    logic             flag_q, flag_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        flag_d  = flag_q;
        count_d = count_q;
        if (ov_evt && ov_clr) begin
            flag_d  = ENABLE;
            count_d = CNT_W'(1);
        end else if (ov_clr) begin
            flag_d  = DISABLE;
            count_d = '0;
        end else if (ov_evt) begin
            flag_d  = ENABLE;
            if (count_q != {CNT_W{1'b1}})
                count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q  <= DISABLE;
            count_q <= '0;
        end else begin
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign ov_flag  = flag_q;
    assign ov_count = count_q;

endmodule

// File: rtl/alu_ex_reg.sv
// EX/MEM pipeline register with overflow exception conversion and overflow statistics.
// Defining ALU_EX_FWD_EN adds the fwd_valid/fwd_addr/fwd_data bypass outputs.
module alu_ex_reg
    import alu_ex_reg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_en,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_gpr_we,
    input  logic [EXP_W-1:0]  id_exp_code,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_of,
    input  logic              ov_clr,
    output logic              ex_en,
    output logic [DATA_W-1:0] ex_out,
    output logic [ADDR_W-1:0] ex_dst_addr,
    output logic              ex_gpr_we,
    output logic [EXP_W-1:0]  ex_exp_code,
`ifdef ALU_EX_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              ov_flag,
    output logic [CNT_W-1:0]  ov_count
);

    logic              en_q, en_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              we_q, we_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [EXP_W-1:0]  load_exp;
    logic              ov_evt;

    assign load_exp = sel_exp(id_exp_code, alu_of);
    // Only a real load that produces the overflow code counts; stalls never do.
    assign ov_evt   = !flush && !stall && id_en && (load_exp == EXP_OVF) && (id_exp_code == EXP_NO);

    always_comb begin
        en_d  = en_q;
        out_d = out_q;
        dst_d = dst_q;
        we_d  = we_q;
        exp_d = exp_q;
        if (flush || (!stall && !id_en)) begin
            en_d  = DISABLE;
            out_d = '0;
            dst_d = '0;
            we_d  = DISABLE;
            exp_d = EXP_NO;
        end else if (!stall) begin
            en_d  = ENABLE;
            out_d = alu_out;
            dst_d = id_dst_addr;
            exp_d = load_exp;
            we_d  = (load_exp == EXP_OVF && id_exp_code == EXP_NO) ? DISABLE : id_gpr_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= DISABLE;
            out_q <= '0;
            dst_q <= '0;
            we_q  <= DISABLE;
            exp_q <= EXP_NO;
        end else begin
            en_q  <= en_d;
            out_q <= out_d;
            dst_q <= dst_d;
            we_q  <= we_d;
            exp_q <= exp_d;
        end
    end

    assign ex_en       = en_q;
    assign ex_out      = out_q;
    assign ex_dst_addr = dst_q;
    assign ex_gpr_we   = we_q;
    assign ex_exp_code = exp_q;

`ifdef ALU_EX_FWD_EN
    assign fwd_valid = en_q & we_q;
    assign fwd_addr  = dst_q;
    assign fwd_data  = out_q;
`endif

    ex_ov_stat #(
        .CNT_W (CNT_W)
    ) u_ov_stat (
        .clk      (clk),
        .reset    (reset),
        .ov_evt   (ov_evt),
        .ov_clr   (ov_clr),
        .ov_flag  (ov_flag),
        .ov_count (ov_count)
    );

endmodule

// File: tb/tb_alu_ex_reg.sv
// Directed bench for alu_ex_reg: per-cycle comparison against a behavioural model plus literal checks.
module tb_alu_ex_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_en, id_gpr_we, alu_of, ov_clr;
    logic [4:0]  id_dst_addr;
    logic [2:0]  id_exp_code;
    logic [23:0] alu_out;
    logic        ex_en, ex_gpr_we, ov_flag;
    logic [23:0] ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [7:0]  ov_count;
`ifdef ALU_EX_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [23:0] fwd_data;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clk = ~clk;

    alu_ex_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_en(id_en),
        .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .id_exp_code(id_exp_code),
        .alu_out(alu_out), .alu_of(alu_of), .ov_clr(ov_clr),
        .ex_en(ex_en), .ex_out(ex_out), .ex_dst_addr(ex_dst_addr), .ex_gpr_we(ex_gpr_we),
        .ex_exp_code(ex_exp_code),
`ifdef ALU_EX_FWD_EN
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
        .ov_flag(ov_flag), .ov_count(ov_count)
    );

    // Behavioural model: what the stage should hold after each edge.
    logic        m_en, m_we, m_flag;
    logic [23:0] m_out;
    logic [4:0]  m_dst;
    logic [2:0]  m_exp;
    int          m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_en <= 0; m_we <= 0; m_flag <= 0; m_out <= 0; m_dst <= 0; m_exp <= 0; m_cnt <= 0;
        end else begin
            bit ovf;
            ovf = 0;
            if (flush || (!stall && !id_en)) begin
                m_en <= 0; m_we <= 0; m_out <= 0; m_dst <= 0; m_exp <= 0;
            end else if (!stall) begin
                m_en  <= 1;
                m_out <= alu_out;
                m_dst <= id_dst_addr;
                if (id_exp_code != 0) begin
                    m_exp <= id_exp_code;
                    m_we  <= id_gpr_we;
                end else if (alu_of) begin
                    m_exp <= 3'd4;
                    m_we  <= 0;
                    ovf = 1;
                end else begin
                    m_exp <= 0;
                    m_we  <= id_gpr_we;
                end
            end
            if (ovf) begin
                m_flag <= 1;
                m_cnt  <= ov_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (ov_clr) begin
                m_flag <= 0;
                m_cnt  <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_model", {ex_en, ex_out, ex_dst_addr, ex_gpr_we, ex_exp_code, ov_flag, ov_count},
                  {m_en, m_out, m_dst, m_we, m_exp, m_flag, 8'(m_cnt)});
`ifdef ALU_EX_FWD_EN
            check("fwd_model", {fwd_valid, fwd_addr, fwd_data}, {m_en & m_we, m_dst, m_out});
`endif
        end
    end

    task automatic step(input logic en, input logic [4:0] dst, input logic we, input logic [2:0] ec,
                        input logic [23:0] res, input logic of, input logic stl, input logic fl,
                        input logic clr, input logic rst);
        id_en = en; id_dst_addr = dst; id_gpr_we = we; id_exp_code = ec;
        alu_out = res; alu_of = of; stall = stl; flush = fl; ov_clr = clr; reset = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        chk_en = 1'b1;
        check("reset_state", {ex_en, ex_out, ex_dst_addr, ex_gpr_we, ex_exp_code, ov_flag, ov_count}, 0);

        step(1, 5'd3, 1, 0, 24'h800000, 1, 0, 0, 0, 0);
        check("ovf_vector", {ex_en, ex_out, ex_gpr_we, ex_exp_code, ov_flag, ov_count},
              {1'b1, 24'h800000, 1'b0, 3'd4, 1'b1, 8'd1});
        $display("txn ovf: ex_out=%h exp=%0d count=%0d", ex_out, ex_exp_code, ov_count);

        step(1, 5'd7, 1, 0, 24'h000003, 0, 0, 0, 0, 0);
        check("plain_load", {ex_en, ex_out, ex_dst_addr, ex_gpr_we, ex_exp_code},
              {1'b1, 24'd3, 5'd7, 1'b1, 3'd0});
        $display("txn load: ex_out=%h dst=%0d we=%0d", ex_out, ex_dst_addr, ex_gpr_we);

        step(1, 5'd9, 1, 0, 24'h000123, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 5'(10 + i), 1, 0, 24'(32'hABC0 + i), 1, 1, 0, 0, 0);
            check("stall_hold", {ex_en, ex_out, ex_dst_addr, ex_gpr_we, ov_count},
                  {1'b1, 24'h000123, 5'd9, 1'b1, 8'd1});
            $display("txn stall %0d: ex_out=%h count=%0d", i, ex_out, ov_count);
        end
        step(1, 5'd11, 1, 0, 24'h555555, 1, 1, 1, 0, 0);
        check("flush_over_stall", {ex_en, ex_out, ex_gpr_we, ex_exp_code, ov_count},
              {1'b0, 24'h0, 1'b0, 3'd0, 8'd1});
        $display("txn flush+stall: ex_en=%0d", ex_en);

        step(1, 5'd4, 1, 3'd1, 24'h7FFFFF, 1, 0, 0, 0, 0);
        check("upstream_exp", {ex_exp_code, ov_count}, {3'd1, 8'd1});
        $display("txn upstream exp: exp=%0d count=%0d", ex_exp_code, ov_count);

        step(0, 5'd4, 1, 0, 24'h1, 1, 0, 0, 0, 0);
        check("idle_bubble", {ex_en, ex_out, ex_dst_addr, ov_count}, {1'b0, 24'h0, 5'd0, 8'd1});

        for (int i = 0; i < 300; i++) step(1, 5'd2, 1, 0, 24'(i), 1, 0, 0, 0, 0);
        check("saturate", {ov_flag, ov_count}, {1'b1, 8'd255});
        $display("txn 300 ovf: count=%0d", ov_count);

        step(1, 5'd2, 1, 0, 24'h10, 1, 0, 0, 1, 0);
        check("clr_vs_ovf", {ov_flag, ov_count}, {1'b1, 8'd1});
        $display("txn clr+ovf: flag=%0d count=%0d", ov_flag, ov_count);

        step(1, 5'd2, 1, 0, 24'h10, 0, 0, 0, 1, 0);
        check("clr_only", {ov_flag, ov_count}, {1'b0, 8'd0});

        step(1, 5'd1, 1, 0, 24'h0, 1, 1, 0, 0, 0);
        check("stall_no_count", ov_count, 8'd0);

        step(1, 5'd6, 1, 0, 24'hABCDEF, 0, 0, 0, 0, 0);
        step(1, 5'd6, 1, 0, 24'h1, 1, 1, 0, 0, 1);
        check("reset_mid_stall", {ex_en, ex_out, ex_dst_addr, ex_gpr_we, ex_exp_code, ov_flag, ov_count}, 0);
`ifdef ALU_EX_FWD_EN
        check("reset_fwd_valid", fwd_valid, 0);
`endif
        $display("txn reset mid-stall: ex_en=%0d", ex_en);

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
